// File: rtl/gol_pkg.sv
// gol_pkg: definitions shared across the Game of Life display path.
// Contains the game-mode encodings, the board geometry, the scan FSM state
// type, and a helper that converts a row index to a one-hot row drive.
package gol_pkg;

    // Game mode encodings, as presented on the datapath's state output
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PROGRAM = 2'b01;
    localparam logic [1:0] ST_RUN     = 2'b10;
    localparam logic [1:0] ST_PAUSE   = 2'b11;

    // Board geometry
    localparam int GRID_DIM   = 8;
    localparam int GRID_CELLS = 64;

    // Scan FSM states
    typedef enum logic [1:0] {
        SCAN_IDLE = 2'b00,
        LOAD      = 2'b01,
        ACTIVE    = 2'b10,
        BLANK     = 2'b11
    } scan_state_t;

    // One-hot row drive for a row index
    function automatic logic [GRID_DIM-1:0] row_onehot(input logic [2:0] row);
        return 8'b0000_0001 << row;
    endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// scan_tick_counter: loadable down-counter with a terminal-count flag.
// A load sets the count.  Otherwise the count decrements and stops at zero.
// The tc flag is high while the count is zero, so a load of N-1 gives a
// dwell of N cycles before tc is seen.
module scan_tick_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Reload on request, otherwise count down and hold at zero
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/grid_scan_driver.sv
// grid_scan_driver: row-multiplexed scan driver for the 8x8 Game of Life LED
// matrix.  The board is snapshotted once per frame in LOAD.  Each row is then
// lit for ROW_TICKS-BLANK_TICKS cycles, followed by BLANK_TICKS dark cycles.
// Optional feature: define GRID_SCAN_BLINK_EN to blink the display while the
// game is in PAUSE.  The blink half-period is BLINK_FRAMES frames.
module grid_scan_driver
    import gol_pkg::*;
#(
    parameter int ROW_TICKS    = 1000,
    parameter int BLANK_TICKS  = 50,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clka,
    input  logic        rst_n,
    input  logic [63:0] grid,
    input  logic [1:0]  state,
    input  logic        en,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_start
);

    localparam int CNT_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam logic [CNT_W-1:0] ACTIVE_RELOAD = CNT_W'(ROW_TICKS - BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD  = CNT_W'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);
    localparam logic             HAS_BLANK     = (BLANK_TICKS > 0) ? 1'b1 : 1'b0;
    localparam logic [2:0]       ROW_LAST      = 3'(GRID_DIM - 1);

    scan_state_t           scan_state_r, scan_state_s;
    logic [2:0]            row_r, row_s;
    logic [GRID_CELLS-1:0] frame_buf_r, frame_buf_s;
    logic                  cnt_load_s;
    logic [CNT_W-1:0]      cnt_load_val_s;
    logic                  cnt_tc_s;
    logic                  row_done_s;
    logic                  load_exit_s;
    logic                  blink_phase_s;
    logic [7:0]            row_sel_r, row_sel_s;
    logic [7:0]            col_data_r, col_data_s;
    logic                  frame_start_r, frame_start_s;

    scan_tick_counter #(
        .WIDTH    (CNT_W)
    ) u_tick (
        .clka     (clka),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .tc       (cnt_tc_s)
    );

    // Next scan state, row index, snapshot and dwell-counter reloads
    always_comb begin
        scan_state_s   = scan_state_r;
        row_s          = row_r;
        frame_buf_s    = frame_buf_r;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = ACTIVE_RELOAD;
        row_done_s     = 1'b0;
        load_exit_s    = 1'b0;
        if (!en) begin
            scan_state_s = SCAN_IDLE;
        end else begin
            case (scan_state_r)
                SCAN_IDLE: begin
                    scan_state_s = LOAD;
                end
                LOAD: begin
                    frame_buf_s    = grid;
                    row_s          = 3'd0;
                    scan_state_s   = ACTIVE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = ACTIVE_RELOAD;
                    load_exit_s    = 1'b1;
                end
                ACTIVE: begin
                    if (cnt_tc_s) begin
                        if (HAS_BLANK) begin
                            scan_state_s   = BLANK;
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = BLANK_RELOAD;
                        end else begin
                            row_done_s = 1'b1;
                        end
                    end else begin
                        scan_state_s = ACTIVE;
                    end
                end
                BLANK: begin
                    if (cnt_tc_s) begin
                        row_done_s = 1'b1;
                    end else begin
                        scan_state_s = BLANK;
                    end
                end
                default: begin
                    scan_state_s = SCAN_IDLE;
                end
            endcase
            // End of a row slot: advance to the next row or start a new frame
            if (row_done_s) begin
                if (row_r == ROW_LAST) begin
                    scan_state_s = LOAD;
                end else begin
                    row_s          = row_r + 3'd1;
                    scan_state_s   = ACTIVE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = ACTIVE_RELOAD;
                end
            end else begin
                row_s = row_s;
            end
        end
    end

`ifdef GRID_SCAN_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_s;
    logic               blink_next_r, blink_next_s;
    logic               blink_phase_r;

    // Per-frame blink decision, taken only as each new snapshot is loaded
    always_comb begin
        blink_cnt_s   = blink_cnt_r;
        blink_next_s  = blink_next_r;
        blink_phase_s = blink_phase_r;
        if (load_exit_s) begin
            if (state == ST_PAUSE) begin
                blink_phase_s = blink_next_r;
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_s  = {BLINK_W{1'b0}};
                    blink_next_s = ~blink_next_r;
                end else begin
                    blink_cnt_s = blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
                end
            end else begin
                blink_cnt_s   = {BLINK_W{1'b0}};
                blink_next_s  = 1'b0;
                blink_phase_s = 1'b0;
            end
        end else begin
            blink_phase_s = blink_phase_r;
        end
    end

    // Blink frame counter and phase registers
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_next_r  <= 1'b0;
            blink_phase_r <= 1'b0;
        end else begin
            blink_cnt_r   <= blink_cnt_s;
            blink_next_r  <= blink_next_s;
            blink_phase_r <= blink_phase_s;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_state_s;
    assign unused_state_s = ^state;
    assign blink_phase_s  = 1'b0;
`endif

    // Output values follow the state being entered, so registering them keeps them aligned with the FSM
    always_comb begin
        frame_start_s = (scan_state_s == LOAD);
        if (scan_state_s == ACTIVE) begin
            row_sel_s  = row_onehot(row_s);
            col_data_s = blink_phase_s ? 8'h00 : frame_buf_s[{row_s, 3'b000} +: GRID_DIM];
        end else begin
            row_sel_s  = 8'h00;
            col_data_s = 8'h00;
        end
    end

    // FSM state, row index, frame snapshot and registered outputs
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            scan_state_r  <= SCAN_IDLE;
            row_r         <= 3'd0;
            frame_buf_r   <= {GRID_CELLS{1'b0}};
            row_sel_r     <= 8'h00;
            col_data_r    <= 8'h00;
            frame_start_r <= 1'b0;
        end else begin
            scan_state_r  <= scan_state_s;
            row_r         <= row_s;
            frame_buf_r   <= frame_buf_s;
            row_sel_r     <= row_sel_s;
            col_data_r    <= col_data_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign row_sel     = row_sel_r;
    assign col_data    = col_data_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_grid_scan_driver.sv
// tb_grid_scan_driver: self-checking bench for grid_scan_driver.
// Two instances are driven with the same inputs.  One has ROW_TICKS=10 and
// BLANK_TICKS=2; the other has ROW_TICKS=10 and BLANK_TICKS=0.  A reference
// model tracks each instance's position within the frame as a plain integer.
// Expected outputs are derived from that position with integer arithmetic.
module tb_grid_scan_driver;

    localparam int RT    = 10;
    localparam int BF    = 2;
    localparam int FRAME = 1 + 8 * RT;

    logic        clka = 1'b0;
    logic        rst_n;
    logic [63:0] grid;
    logic [1:0]  state;
    logic        en;
    logic [7:0]  row_sel_a, col_data_a, row_sel_b, col_data_b;
    logic        frame_start_a, frame_start_b;

    grid_scan_driver #(.ROW_TICKS(RT), .BLANK_TICKS(2), .BLINK_FRAMES(BF)) u_dut_blank (
        .clka(clka), .rst_n(rst_n), .grid(grid), .state(state), .en(en),
        .row_sel(row_sel_a), .col_data(col_data_a), .frame_start(frame_start_a)
    );

    grid_scan_driver #(.ROW_TICKS(RT), .BLANK_TICKS(0), .BLINK_FRAMES(BF)) u_dut_noblank (
        .clka(clka), .rst_n(rst_n), .grid(grid), .state(state), .en(en),
        .row_sel(row_sel_b), .col_data(col_data_b), .frame_start(frame_start_b)
    );

    always #5 clka = ~clka;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_fs  = -1;
    // Model state per instance.  pos is -1 when idle, 0 in the snapshot cycle,
    // and 1..8*RT for the row slots of the frame.
    int          m_pos[2];
    logic [63:0] m_snap[2];
    int          m_npause[2];
    bit          m_dark[2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int blank_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit lit(input int i);
        int q;
        if (m_pos[i] <= 0) return 1'b0;
        q = m_pos[i] - 1;
        return (q % RT) < (RT - blank_of(i));
    endfunction

    function automatic logic [7:0] exp_row(input int i);
        int r;
        if (!lit(i)) return 8'h00;
        r = (m_pos[i] - 1) / RT;
        return 8'(1 << r);
    endfunction

    function automatic logic [7:0] exp_col(input int i);
        int          r;
        logic [63:0] s;
        if (!lit(i) || m_dark[i]) return 8'h00;
        r = (m_pos[i] - 1) / RT;
        s = m_snap[i];
        return s[r*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i]    = -1;
            m_snap[i]   = 64'h0;
            m_npause[i] = 0;
            m_dark[i]   = 1'b0;
        end
        last_fs = -1;
    endtask

    // Advance the model by one rising edge, using the inputs held across that edge
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!en) begin
                    m_pos[i] = -1;
                end else if (m_pos[i] < 0) begin
                    m_pos[i] = 0;
                end else begin
                    if (m_pos[i] == 0) begin
                        m_snap[i] = grid;
`ifdef GRID_SCAN_BLINK_EN
                        if (state == 2'b11) begin
                            m_dark[i] = ((m_npause[i] / BF) % 2) == 1;
                            m_npause[i]++;
                        end else begin
                            m_npause[i] = 0;
                            m_dark[i]   = 1'b0;
                        end
`endif
                    end
                    m_pos[i] = (m_pos[i] == 8 * RT) ? 0 : m_pos[i] + 1;
                end
            end
            if (!en) last_fs = -1;
        end
    endtask

    task automatic tick();
        @(posedge clka);
        cyc++;
        model_edge();
        #1;
        check_eq("row_sel_blank",       64'(row_sel_a),     64'(exp_row(0)));
        check_eq("col_data_blank",      64'(col_data_a),    64'(exp_col(0)));
        check_eq("frame_start_blank",   64'(frame_start_a), 64'(m_pos[0] == 0));
        check_eq("row_sel_noblank",     64'(row_sel_b),     64'(exp_row(1)));
        check_eq("col_data_noblank",    64'(col_data_b),    64'(exp_col(1)));
        check_eq("frame_start_noblank", 64'(frame_start_b), 64'(m_pos[1] == 0));
        if (frame_start_a) begin
            if (last_fs >= 0) check_eq("frame_period", 64'(cyc - last_fs), 64'(FRAME));
            last_fs = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance until the model says instance 0 is lighting the given row, within a budget
    task automatic wait_row(input int target, input int budget);
        bit reached = 1'b0;
        for (int k = 0; k < budget && !reached; k++) begin
            tick();
            if (exp_row(0) == 8'(1 << target)) reached = 1'b1;
        end
        check_eq("wait_row", 64'(reached), 64'd1);
    endtask

    // Assert reset between edges; the outputs must clear without waiting for a clock
    task automatic async_reset(input bit drop_en);
        rst_n = 1'b0;
        #1;
        check_eq("rst_row_sel_blank",     64'(row_sel_a),     64'd0);
        check_eq("rst_col_data_blank",    64'(col_data_a),    64'd0);
        check_eq("rst_frame_start_blank", 64'(frame_start_a), 64'd0);
        check_eq("rst_row_sel_noblank",   64'(row_sel_b),     64'd0);
        check_eq("rst_col_data_noblank",  64'(col_data_b),    64'd0);
        model_reset();
        if (drop_en) en = 1'b0;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        grid  = 64'h0;
        state = 2'b10;
        model_reset();
        run(3);
        rst_n = 1'b1;
        run(3);

        // Diagonal board: row r shows only column r
        grid = 64'h8040201008040201;
        en   = 1'b1;
        run(2 * FRAME + 5);

        // Reset in the middle of a lit row, then stay disabled
        wait_row(4, FRAME);
        run(2);
        async_reset(1'b1);
        run(100);

        // Snapshot: board changes during row 3 must not show until the next frame
        grid = 64'hFFFF_FFFF_FFFF_FFFF;
        en   = 1'b1;
        run(FRAME);
        wait_row(3, FRAME);
        grid = 64'h0;
        run(2 * FRAME);

        // Enable drop in row 5, then restart
        grid = {$urandom, $urandom};
        wait_row(5, FRAME);
        en = 1'b0;
        run(4);
        en = 1'b1;
        run(FRAME + 3);

        // Pause with a full board: blinks when compiled in, steady otherwise
        state = 2'b11;
        grid  = 64'hFFFF_FFFF_FFFF_FFFF;
        en    = 1'b0;
        run(1);
        en = 1'b1;
        run(7 * FRAME);
        state = 2'b10;
        run(2 * FRAME);

        // Randomized traffic
        for (int it = 0; it < 5000; it++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 25) begin
                grid = {$urandom, $urandom};
            end else if (r < 29) begin
                en = ~en;
            end else if (r < 36) begin
                state = 2'($urandom_range(0, 3));
            end else if (r == 40) begin
                async_reset(1'b0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
